mem_arbiter: RTL
================

# mem_arbiter

Shares one single-port unified memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. It arbitrates, sequences one outstanding transaction at a time over a req/gnt/rvalid memory handshake, and returns stall signals that freeze the fetch and memory stages of the pipeline. Data accesses are prioritised because they belong to older instructions. A run-length limit bounds how long fetch can be starved.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DM_RUN, 4, maximum consecutive data grants while fetch waits (≥1)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data; valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- stallF  out  1  if_req & ~if_valid
- dm_req  in  1  data request; held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; valid with dm_valid
- dm_valid  out  1  one-cycle data completion pulse (loads and stores)
- stallM  out  1  dm_req & ~dm_valid
- mem_req, mem_we  out  1  memory request / write enable (registered)
- mem_addr, mem_wdata  out  ADDR_W / DATA_W  registered request payload
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  response (read data or write ack)
- mem_rdata  in  DATA_W  read data
- perf_if_grants, perf_dm_grants, perf_stall_cycles  out  32  performance counters (see Configuration)

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - ISSUE: mem_req is asserted and held until mem_gnt.
  - WAIT_RSP: waiting for mem_rvalid.
- IDLE transitions:
  - No requests: stay in IDLE.
  - Any request: latch the winner's owner, we, addr and wdata into the mem_* registers; go to ISSUE.
  - Fetch requests are treated as loads (mem_we=0).
- Arbitration when both requests are present: DM wins, unless run_cnt == MAX_DM_RUN, in which case IF wins.
- run_cnt:
  - Increments on a DM grant while if_req=1.
  - Clears on any IF grant, and whenever if_req=0 in IDLE.
  - Saturates at MAX_DM_RUN. Width is $clog2(MAX_DM_RUN+1).
- ISSUE: on mem_gnt, deassert mem_req next cycle and go to WAIT_RSP. mem_gnt and mem_rvalid in the same cycle are legal; treat as WAIT_RSP already satisfied and complete directly.
- WAIT_RSP: on mem_rvalid, pass mem_rdata to the owner's rdata. The owner's valid equals mem_rvalid (combinational) in that cycle. Return to IDLE.
- The non-owner's valid is always 0. if_rdata and dm_rdata hold their last value otherwise.
- Requester drops req mid-transaction: the protocol forbids it. The arbiter still completes the transaction and pulses valid.
- mem_rvalid outside WAIT_RSP is ignored.

## Timing
- Reset values:
  - Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0, perf_*=0.
  - Internal: state=IDLE, run_cnt=0.
  - stallF and stallM follow their inputs.
- Reset asserted mid-transaction aborts it immediately, with no response delivered. The memory must be reset by the same signal.
- Minimum latency from req at IDLE to valid is 3 cycles, with mem_gnt in the first ISSUE cycle and mem_rvalid one cycle later:
  - cycle 0: req sampled in IDLE.
  - cycle 1: mem_req high, gnt.
  - cycle 2: rvalid and valid.
- The next arbitration happens in the IDLE cycle after completion, so there is at most one transaction every 3 cycles.
- Back-to-back: a requester whose valid pulsed may present a new request the next cycle; it is sampled in IDLE.

## Configuration
- ARB_PERF_EN defined:
  - perf_if_grants and perf_dm_grants increment on each grant in IDLE.
  - perf_stall_cycles increments each cycle with stallF | stallM.
  - All counters are 32-bit and wrap.
- ARB_PERF_EN undefined: perf_* ports remain, tied to 0, and no counter flops are built.

## Structure
- Package mem_arb_pkg:
  - arb_state_t {ST_IDLE, ST_ISSUE, ST_WAIT_RSP}
  - owner_t {OWN_IF, OWN_DM}
  - default width constants
- Sub-module arb_perf_ctr (one 32-bit enable-driven counter, instantiated three times under ARB_PERF_EN).

## Test plan
- Single fetch: if_req=1, if_addr=0x10, gnt in the first ISSUE cycle, rvalid next cycle with rdata=0x00500113 -> if_valid pulses at cycle 2, if_rdata=0x00500113, stallF high cycles 0–1.
- Load/store: dm_we=1, addr=0x64, wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x64, mem_wdata=0xDEADBEEF; dm_valid on the ack. Then a load of 0x64 returns 0xDEADBEEF.
- Priority and starvation guard: if_req and dm_req both held permanently, MAX_DM_RUN=4 -> grant order DM, DM, DM, DM, IF, DM, DM, DM, DM, IF.
- Slow memory: mem_gnt delayed 5 cycles, rvalid delayed 3 more -> mem_req held stable for 5 cycles, exactly one valid pulse, stalls stay high throughout.
- Reset in WAIT_RSP: reset low for one cycle before rvalid -> no valid pulse, mem_req=0, state IDLE, perf_*=0. A subsequent fetch completes normally.
- ARB_PERF_EN: 3 IF and 2 DM transactions at 3-cycle minimum latency -> perf_if_grants=3, perf_dm_grants=2, perf_stall_cycles equals the observed count of stall-high cycles. Built without ARB_PERF_EN, all perf_* read 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned MAX_DM_RUN_DEF = 4;
    localparam int unsigned PERF_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RSP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/arb_perf_ctr.sv
// Free-running 32-bit event counter that wraps; advances on en.
module arb_perf_ctr
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [PERF_W-1:0] count
);

    // Count enabled cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between fetch and data ports, one
// outstanding transaction at a time. Data wins ties except when fetch has
// been passed over MAX_DM_RUN times in a row.
// Optional performance counters are built when ARB_PERF_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned MAX_DM_RUN = MAX_DM_RUN_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stallF,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stallM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [PERF_W-1:0] perf_if_grants,
    output logic [PERF_W-1:0] perf_dm_grants,
    output logic [PERF_W-1:0] perf_stall_cycles
);

    localparam int unsigned RUN_W = $clog2(MAX_DM_RUN + 1);

    arb_state_t        state;
    owner_t            owner;
    logic [RUN_W-1:0]  run_cnt;
    logic              run_full_c;
    logic              grant_if_c;
    logic              grant_dm_c;
    logic              done_c;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    assign run_full_c = (run_cnt == RUN_W'(MAX_DM_RUN));

    // Arbitration in IDLE: data first, fetch once the run limit is reached
    always_comb begin
        grant_if_c = 1'b0;
        grant_dm_c = 1'b0;
        if (state == ST_IDLE) begin
            if (if_req && dm_req) begin
                grant_if_c = run_full_c;
                grant_dm_c = !run_full_c;
            end else begin
                grant_if_c = if_req;
                grant_dm_c = dm_req;
            end
        end
    end

    // Completion: response in WAIT_RSP, or grant and response together in ISSUE
    assign done_c = mem_rvalid &&
                    ((state == ST_WAIT_RSP) || ((state == ST_ISSUE) && mem_gnt));

    assign if_valid = done_c && (owner == OWN_IF);
    assign dm_valid = done_c && (owner == OWN_DM);
    assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
    assign dm_rdata = dm_valid ? mem_rdata : dm_rdata_q;
    assign stallF   = if_req && !if_valid;
    assign stallM   = dm_req && !dm_valid;

    // Transaction sequencer with registered memory request payload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            run_cnt   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_if_c) begin
                        owner     <= OWN_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        state     <= ST_ISSUE;
                    end else if (grant_dm_c) begin
                        owner     <= OWN_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        state     <= ST_ISSUE;
                    end
                    if (!if_req || grant_if_c) begin
                        run_cnt <= '0;
                    end else if (grant_dm_c && !run_full_c) begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= mem_rvalid ? ST_IDLE : ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (mem_rvalid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Hold last delivered read data per port between completions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (if_valid) if_rdata_q <= mem_rdata;
            if (dm_valid) dm_rdata_q <= mem_rdata;
        end
    end

`ifdef ARB_PERF_EN
    arb_perf_ctr u_ctr_if (
        .clk   (clk),
        .reset (reset),
        .en    (grant_if_c),
        .count (perf_if_grants)
    );

    arb_perf_ctr u_ctr_dm (
        .clk   (clk),
        .reset (reset),
        .en    (grant_dm_c),
        .count (perf_dm_grants)
    );

    arb_perf_ctr u_ctr_stall (
        .clk   (clk),
        .reset (reset),
        .en    (stallF || stallM),
        .count (perf_stall_cycles)
    );
`else
    assign perf_if_grants    = '0;
    assign perf_dm_grants    = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule
